// File: rtl/add_pkg.sv
// +----------------------------------------------------------------------+
// | add_pkg : shared types and sizing helpers for the serial adder       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-digit operation still needs a one-bit counter.
  function automatic int calc_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_fa_slice.sv
// +----------------------------------------------------------------------+
// | serial_fa_slice : one-bit combinational full adder                   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module serial_fa_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

`default_nettype wire

// File: rtl/add_serial_nbit.sv
// +----------------------------------------------------------------------+
// | add_serial_nbit : DIGIT-bits-per-clock serial adder/subtractor       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module add_serial_nbit
  import add_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = calc_n(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(N);

  generate
    if ((WIDTH < 2) || (WIDTH % DIGIT != 0)) begin : g_param_check
      $error("add_serial_nbit: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT:0]     w_c;
  logic [DIGIT-1:0]   w_s;
  logic [WIDTH-1:0]   w_acc_next;
  logic               w_last;

  assign w_c[0] = carry_q;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_slice
      serial_fa_slice u_slice (
        .a_i    (op_a_q[i]),
        .b_i    (op_b_q[i]),
        .cin_i  (w_c[i]),
        .sum_o  (w_s[i]),
        .cout_o (w_c[i+1])
      );
    end
  endgenerate

  // New sum digit enters at the top so the LSB digit ends up at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_acc_full
      assign w_acc_next = w_s;
    end else begin : g_acc_shift
      assign w_acc_next = {w_s, acc_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_last = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          op_a_d  = a;
          op_b_d  = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        op_a_d  = op_a_q >> DIGIT;
        op_b_d  = op_b_q >> DIGIT;
        acc_d   = w_acc_next;
        carry_d = w_c[DIGIT];
        cnt_d   = cnt_q + CNT_W'(1);
        if (w_last) begin
          result_d = w_acc_next;
          cout_d   = w_c[DIGIT];
          ovf_d    = w_c[DIGIT] ^ w_c[DIGIT-1];
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_add_serial_nbit.sv
// +----------------------------------------------------------------------+
// | tb_add_serial_nbit : directed self-checking bench, DIGIT=1 and 4     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_add_serial_nbit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done, cout, ovf;
  logic [7:0] result;

  logic       start4, sub4, cin4;
  logic [7:0] a4, b4;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] result4;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] r;
    logic       c;
    logic       o;
  } vec_t;

  always #5 clk = ~clk;

  add_serial_nbit #(.WIDTH(8), .DIGIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  add_serial_nbit #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
  );

  task automatic test_reset;
    rst_n = 1'b0; start = 0; sub = 0; cin = 0; a = 0; b = 0;
    start4 = 0; sub4 = 0; cin4 = 0; a4 = 0; b4 = 0;
    #12;
    n_vec++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result got=%h exp=00", result); end
    n_vec++; if ({cout, ovf} !== 2'b00) begin n_err++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL idle_after_reset got=%b exp=00", {busy, done}); end
  endtask

  // Case 1 with a full cycle-by-cycle timeline and output stability check.
  task automatic test_add_basic;
    a = 8'h0F; b = 8'h01; cin = 0; sub = 0; start = 1;
    @(posedge clk); #1;
    start = 0; a = 8'hA5; b = 8'h3C; cin = 1; sub = 1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      n_vec++;
      if ({busy, done} !== {(i < 8), (i == 8)}) begin
        n_err++; $display("FAIL basic_handshake cyc=%0d got busy=%b done=%b exp busy=%b done=%b",
                          i, busy, done, (i < 8), (i == 8));
      end
      if (i < 8) begin
        n_vec++;
        if ({result, cout, ovf} !== 10'h0) begin
          n_err++; $display("FAIL basic_stable cyc=%0d got=%h/%b/%b exp=00/0/0", i, result, cout, ovf);
        end
      end
    end
    n_vec++;
    if ({result, cout, ovf} !== {8'h10, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL basic_result got=%h c=%b v=%b exp=10 c=0 v=0", result, cout, ovf);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done, result} !== {2'b00, 8'h10}) begin
      n_err++; $display("FAIL basic_idle got busy=%b done=%b r=%h exp 0 0 10", busy, done, result);
    end
  endtask

  task automatic run_table(input vec_t tbl[5], input int cnt, input string tag);
    for (int v = 0; v < cnt; v++) begin
      a = tbl[v].a; b = tbl[v].b; cin = tbl[v].cin; sub = tbl[v].sub; start = 1;
      @(posedge clk); #1;
      start = 0; a = ~a; b = ~b; cin = ~cin; sub = ~sub;
      repeat (7) @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0) begin n_err++; $display("FAIL %s_early v=%0d done=%b exp=0", tag, v, done); end
      @(posedge clk); #1;
      n_vec++;
      if ({done, result, cout, ovf} !== {1'b1, tbl[v].r, tbl[v].c, tbl[v].o}) begin
        n_err++; $display("FAIL %s v=%0d got done=%b r=%h c=%b v=%b exp done=1 r=%h c=%b v=%b",
                          tag, v, done, result, cout, ovf, tbl[v].r, tbl[v].c, tbl[v].o);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add_vectors;
    vec_t t[5];
    t[0] = '{a: 8'hFF, b: 8'h01, cin: 0, sub: 0, r: 8'h00, c: 1, o: 0};
    t[1] = '{a: 8'h7F, b: 8'h01, cin: 0, sub: 0, r: 8'h80, c: 0, o: 1};
    t[2] = '{a: 8'h00, b: 8'h00, cin: 1, sub: 0, r: 8'h01, c: 0, o: 0};
    t[3] = '{a: 8'h80, b: 8'h80, cin: 0, sub: 0, r: 8'h00, c: 1, o: 1};
    t[4] = '{a: 8'hC8, b: 8'h37, cin: 1, sub: 0, r: 8'h00, c: 1, o: 0};
    run_table(t, 5, "add");
  endtask

  task automatic test_sub;
    vec_t t[5];
    t[0] = '{a: 8'h05, b: 8'h07, cin: 1, sub: 1, r: 8'hFE, c: 0, o: 0};
    t[1] = '{a: 8'h80, b: 8'h01, cin: 0, sub: 1, r: 8'h7F, c: 1, o: 1};
    t[2] = '{a: 8'h33, b: 8'h33, cin: 1, sub: 1, r: 8'h00, c: 1, o: 0};
    t[3] = '{a: 8'h7F, b: 8'hFF, cin: 0, sub: 1, r: 8'h80, c: 0, o: 1};
    t[4] = '{a: 8'h00, b: 8'h00, cin: 0, sub: 1, r: 8'h00, c: 1, o: 0};
    run_table(t, 5, "sub");
  endtask

  task automatic test_busy_ignore;
    a = 8'h21; b = 8'h13; cin = 0; sub = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55; cin = 1; sub = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL ignore_early done=%b exp=0", done); end
    @(posedge clk); #1;
    n_vec++;
    if ({done, result, cout, ovf} !== {1'b1, 8'h34, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL ignore_result got done=%b r=%h c=%b v=%b exp 1 34 0 0", done, result, cout, ovf);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL ignore_idle got=%b exp=00", {busy, done}); end
  endtask

  // start held high: second op is taken from DONE, so done pulses at +8 and +17.
  task automatic test_back_to_back;
    a = 8'h40; b = 8'h40; cin = 0; sub = 0; start = 1;
    @(posedge clk); #1;
    a = 8'hC0; b = 8'h50;
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk); #1;
      if (i == 9) start = 0;
      if (i == 8) begin
        n_vec++;
        if ({done, busy, result, cout, ovf} !== {2'b10, 8'h80, 1'b0, 1'b1}) begin
          n_err++; $display("FAIL b2b_first got done=%b busy=%b r=%h c=%b v=%b exp 1 0 80 0 1",
                            done, busy, result, cout, ovf);
        end
      end else if (i == 9) begin
        n_vec++;
        if ({done, busy, result} !== {2'b01, 8'h80}) begin
          n_err++; $display("FAIL b2b_nobubble got done=%b busy=%b r=%h exp 0 1 80", done, busy, result);
        end
      end else if (i == 17) begin
        n_vec++;
        if ({done, busy, result, cout, ovf} !== {2'b10, 8'h10, 1'b1, 1'b0}) begin
          n_err++; $display("FAIL b2b_second got done=%b busy=%b r=%h c=%b v=%b exp 1 0 10 1 0",
                            done, busy, result, cout, ovf);
        end
      end else if (i > 9) begin
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL b2b_spurious cyc=%0d done=%b exp=0", i, done); end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    a = 8'h7F; b = 8'h7F; cin = 1; sub = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, result, cout, ovf} !== 12'h0) begin
      n_err++; $display("FAIL async_reset got busy=%b done=%b r=%h c=%b v=%b exp all 0",
                        busy, done, result, cout, ovf);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    a = 8'h12; b = 8'h34; cin = 1; sub = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if ({done, result, cout, ovf} !== {1'b1, 8'h47, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL post_reset got done=%b r=%h c=%b v=%b exp 1 47 0 0", done, result, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_digit4;
    a4 = 8'h9C; b4 = 8'h6A; cin4 = 0; sub4 = 0; start4 = 1;
    @(posedge clk); #1;
    start4 = 0; a4 = 8'h00; b4 = 8'h00;
    n_vec++;
    if ({busy4, done4} !== 2'b10) begin n_err++; $display("FAIL d4_busy got=%b exp=10", {busy4, done4}); end
    @(posedge clk); #1;
    n_vec++;
    if ({busy4, done4, result4} !== {2'b10, 8'h00}) begin
      n_err++; $display("FAIL d4_mid got busy=%b done=%b r=%h exp 1 0 00", busy4, done4, result4);
    end
    @(posedge clk); #1;
    n_vec++;
    if ({done4, result4, cout4, ovf4} !== {1'b1, 8'h06, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL d4_add got done=%b r=%h c=%b v=%b exp 1 06 1 0", done4, result4, cout4, ovf4);
    end
    a4 = 8'h30; b4 = 8'h70; sub4 = 1; cin4 = 0; start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({done4, result4, cout4, ovf4} !== {1'b1, 8'hC0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL d4_sub got done=%b r=%h c=%b v=%b exp 1 C0 0 0", done4, result4, cout4, ovf4);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_vectors();
    test_sub();
    test_busy_ignore();
    test_back_to_back();
    test_async_reset();
    test_digit4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
